// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Function : Multi-cycle ALU: one-cycle add/sub, shift-add multiply and MAC.
// Revision : 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 5,
    parameter int RW    = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result,
    output logic             neg,
    output logic             ovf
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_PW = 2*WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [c_CW-1:0]     r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0]    r_a_q, w_a_d;
    logic [WIDTH-1:0]    r_b_q, w_b_d;
    logic                r_mac_q, w_mac_d;
    logic [c_PW-1:0]     r_prod_q, w_prod_d;
    logic [RW-1:0]       r_result_q, w_result_d;
    logic                r_neg_q, w_neg_d;
    logic                r_ovf_q, w_ovf_d;
    logic                r_done_q, w_done_d;
    logic                r_busy_q, w_busy_d;

    logic [WIDTH:0]      w_add;
    logic [WIDTH:0]      w_sub;
    logic [c_PW-1:0]     w_addend;
    logic [RW:0]         w_mac_sum;

    assign w_add     = {1'b0, a} + {1'b0, b};
    assign w_sub     = {1'b0, a} - {1'b0, b};
    assign w_addend  = {{WIDTH{1'b0}}, r_a_q} << r_cnt_q;
    // Accumulate into the visible result; the extra top bit is the wrap carry.
    assign w_mac_sum = {1'b0, r_result_q} + {{(RW+1-c_PW){1'b0}}, r_prod_q};

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_mac_d    = r_mac_q;
        w_prod_d   = r_prod_q;
        w_result_d = r_result_q;
        w_neg_d    = r_neg_q;
        w_ovf_d    = r_ovf_q;
        w_done_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        w_result_d = op[0] ? {{(RW-WIDTH-1){1'b0}}, w_sub}
                                           : {{(RW-WIDTH-1){1'b0}}, w_add};
                        w_neg_d    = op[0] && (a < b);
                        w_ovf_d    = 1'b0;
                        w_done_d   = 1'b1;
                    end else begin
                        w_a_d     = a;
                        w_b_d     = b;
                        w_mac_d   = op[0];
                        w_prod_d  = '0;
                        w_cnt_d   = '0;
                        w_state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (r_b_q[r_cnt_q]) begin
                    w_prod_d = r_prod_q + w_addend;
                end
                w_cnt_d = r_cnt_q + c_CW'(1);
                if (r_cnt_q == c_CW'(WIDTH-1)) begin
                    w_state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (r_mac_q) begin
                    w_result_d = w_mac_sum[RW-1:0];
                    w_ovf_d    = w_mac_sum[RW];
                end else begin
                    w_result_d = {{(RW-c_PW){1'b0}}, r_prod_q};
                    w_ovf_d    = 1'b0;
                end
                w_neg_d   = 1'b0;
                w_done_d  = 1'b1;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_cnt_q    <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_mac_q    <= 1'b0;
            r_prod_q   <= '0;
            r_result_q <= '0;
            r_neg_q    <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_done_q   <= 1'b0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_mac_q    <= w_mac_d;
            r_prod_q   <= w_prod_d;
            r_result_q <= w_result_d;
            r_neg_q    <= w_neg_d;
            r_ovf_q    <= w_ovf_d;
            r_done_q   <= w_done_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign result = r_result_q;
    assign neg    = r_neg_q;
    assign ovf    = r_ovf_q;

endmodule
`default_nettype wire
